// File: rtl/uart_pkg.sv
// Shared UART types and frame-geometry helpers for the TX/RX pair.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } tx_states_t;

    localparam int TICKS_PER_BIT = 16;

    function automatic int baud_pulse_count(input int sysclk, input int baud);
        return sysclk / (TICKS_PER_BIT * baud);
    endfunction

    function automatic int num_tx_bits(input int data_bits, input int stop_bits);
        return 1 + data_bits + 1 + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// TX FIFO head-word handshake: the FIFO presents a word, the transmitter pops it.
interface uart_tx_fsm_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] Tx_Data_In;
    logic                 Tx_Valid;
    logic                 Tx_Pop;

    modport master (
        output Tx_Data_In,
        output Tx_Valid,
        input  Tx_Pop
    );

    modport slave (
        input  Tx_Data_In,
        input  Tx_Valid,
        output Tx_Pop
    );

endinterface

// File: rtl/uart_baud_tick.sv
// 16x baud clock-enable generator; one tick every PULSE_COUNT+1 clocks.
module uart_baud_tick #(
    parameter int PULSE_COUNT = 0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (PULSE_COUNT > 0) ? $clog2(PULSE_COUNT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(PULSE_COUNT);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST) && !clr_i;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, data MSB first, parity, stop bits; CTS gates frame start.
// Define UART_TX_PARITY_ODD_EN to switch the parity bit from even to odd.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 2,
    parameter int SYSCLOCK_FREQ = 100000,
    parameter int BAUDRATE      = 9600
) (
    input  logic          Clk,
    input  logic          Rst,
    uart_tx_fsm_if.slave  fifo,
    input  logic          CTS,
    output logic          Tx_Out,
    output logic          Tx_Busy,
    output logic          Tx_Done
);

    localparam int BPC = baud_pulse_count(SYSCLOCK_FREQ, BAUDRATE);
    localparam int NB  = num_tx_bits(DATA_BITS, STOP_BITS);
    localparam int BW  = $clog2(NB);
    localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);

    tx_states_t    state_q, state_d;
    logic [NB-1:0] shreg_q, shreg_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          out_q, out_d;
    logic          pop_q, pop_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          start;
    logic          tick;
    logic          par;

`ifdef UART_TX_PARITY_ODD_EN
    assign par = ~^fifo.Tx_Data_In;
`else
    assign par = ^fifo.Tx_Data_In;
`endif

    // Restart the tick phase on capture so every bit spans a full 16 ticks.
    uart_baud_tick #(
        .PULSE_COUNT(BPC)
    ) u_tick (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr_i (start),
        .tick_o(tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        out_d      = 1'b1;
        pop_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        start      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo.Tx_Valid && CTS) begin
                    start      = 1'b1;
                    shreg_d    = {1'b0, fifo.Tx_Data_In, par, {STOP_BITS{1'b1}}};
                    out_d      = 1'b0;
                    pop_d      = 1'b1;
                    busy_d     = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                busy_d = 1'b1;
                out_d  = out_q;
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            out_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                            shreg_d   = shreg_q << 1;
                            out_d     = shreg_q[NB-2];
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            out_q      <= 1'b1;
            pop_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            out_q      <= out_d;
            pop_q      <= pop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Tx_Out      = out_q;
    assign fifo.Tx_Pop = pop_q;
    assign Tx_Busy     = busy_q;
    assign Tx_Done     = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: frame-timeline model checked every cycle plus directed frames.
module tb_uart_tx_fsm;

    localparam int DB     = 8;
    localparam int SB     = 2;
    localparam int SYSCLK = 100000;
    localparam int BAUD   = 9600;
    localparam int BPC    = SYSCLK / (16 * BAUD);
    localparam int BITC   = 16 * (BPC + 1);
    localparam int NBITS  = 1 + DB + 1 + SB;
    localparam int FRAME  = NBITS * BITC;
`ifdef UART_TX_PARITY_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic CTS = 1'b0;
    logic Tx_Out, Tx_Busy, Tx_Done;

    uart_tx_fsm_if #(.DATA_BITS(DB)) fif ();

    uart_tx_fsm #(
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .SYSCLOCK_FREQ(SYSCLK),
        .BAUDRATE     (BAUD)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .fifo   (fif),
        .CTS    (CTS),
        .Tx_Out (Tx_Out),
        .Tx_Busy(Tx_Busy),
        .Tx_Done(Tx_Done)
    );

    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line bit k of a frame carrying d: start, data MSB first, parity, stops.
    function automatic logic line_bit(input logic [DB-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return d[DB-k];
        if (k == DB + 1) return (^d) ^ ODD;
        return 1'b1;
    endfunction

    // Model: clocks elapsed since the capture edge of the frame in flight.
    logic          m_act = 1'b0;
    int            m_t   = 0;
    logic [DB-1:0] m_data = '0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_act = 1'b0;
            m_t   = 0;
        end else if (!m_act) begin
            if (fif.Tx_Valid && CTS) begin
                m_act  = 1'b1;
                m_t    = 0;
                m_data = fif.Tx_Data_In;
            end
        end else begin
            m_t++;
            if (m_t == FRAME + 1) m_act = 1'b0;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge Clk) begin
        logic e_out, e_pop, e_busy, e_done;
        if (chk_en) begin
            e_out = 1'b1; e_pop = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (m_act) begin
                e_busy = 1'b1;
                if (m_t < FRAME) begin
                    e_out = line_bit(m_data, m_t / BITC);
                    e_pop = (m_t == 0);
                end else begin
                    e_done = 1'b1;
                end
            end
            chk("cyc_tx_out", Tx_Out, e_out);
            chk("cyc_tx_pop", fif.Tx_Pop, e_pop);
            chk("cyc_tx_busy", Tx_Busy, e_busy);
            chk("cyc_tx_done", Tx_Done, e_done);
        end
    end

    // Upstream FIFO: advances on the edge where Tx_Pop is high.
    logic [DB-1:0] q[$];
    logic s_out, s_pop, s_busy, s_done;
    int   pops = 0;

    task automatic drive();
        fif.Tx_Valid   = (q.size() > 0);
        fif.Tx_Data_In = (q.size() > 0) ? q[0] : DB'($urandom);
    endtask

    task automatic tick();
        @(negedge Clk);
        s_out = Tx_Out; s_pop = fif.Tx_Pop; s_busy = Tx_Busy; s_done = Tx_Done;
        if (s_pop) pops++;
        @(posedge Clk);
        #1;
        if (s_pop && q.size() > 0) void'(q.pop_front());
        drive();
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input int drop_t,
                              output logic [NBITS-1:0] bits, output int dones);
        q.push_back(d);
        drive();
        dones = 0;
        bits = '0;
        tick();
        for (int t = 0; t <= FRAME + 1; t++) begin
            tick();
            if (t == 0) chk("pop_at_capture", s_pop, 1);
            if (s_done) dones++;
            if (t % BITC == BITC / 2) bits[NBITS-1-t/BITC] = s_out;
            if (t == drop_t) CTS = 1'b0;
        end
        CTS = 1'b1;
    endtask

    initial begin
        logic [NBITS-1:0] bits;
        int dones;
        fif.Tx_Valid = 1'b0;
        fif.Tx_Data_In = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("rst_tx_out", s_out, 1);
        chk("rst_busy", s_busy, 0);
        chk("rst_pop", s_pop, 0);
        chk("rst_done", s_done, 0);

        CTS = 1'b1;
        send_frame(8'hA5, -1, bits, dones);
        chk("a5_bits", bits, {1'b0, 8'hA5, ODD, 2'b11});
        chk("a5_done_cnt", dones, 1);

        send_frame(8'h01, -1, bits, dones);
        chk("x01_bits", bits, {1'b0, 8'h01, ~ODD, 2'b11});

        CTS = 1'b0;
        q.push_back(8'h5C);
        drive();
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("fc_tx_out", s_out, 1);
            chk("fc_pop", s_pop, 0);
            chk("fc_busy", s_busy, 0);
        end
        CTS = 1'b1;
        tick();
        tick();
        chk("fc_start_bit", s_out, 0);
        chk("fc_start_pop", s_pop, 1);
        repeat (FRAME + 2) tick();

        send_frame(8'h3C, 4 * BITC + 3, bits, dones);
        chk("cts_drop_bits", bits, {1'b0, 8'h3C, ODD, 2'b11});
        chk("cts_drop_done", dones, 1);

        q.push_back(8'h00);
        q.push_back(8'hFF);
        drive();
        pops = 0;
        tick();
        for (int t = 0; t <= 2 * FRAME + 3; t++) begin
            tick();
            if (t == FRAME - 1) chk("b2b_stop_end", s_out, 1);
            if (t == FRAME) chk("b2b_gap0", s_out, 1);
            if (t == FRAME + 1) chk("b2b_gap1", s_out, 1);
            if (t == FRAME + 2) chk("b2b_start2", s_out, 0);
            if (t == FRAME + 2) chk("b2b_pop2", s_pop, 1);
            if (t == 9 * BITC + BITC / 2) chk("b2b_par1", s_out, ODD);
            if (t == FRAME + 2 + 9 * BITC + BITC / 2) chk("b2b_par2", s_out, ODD);
        end
        chk("b2b_pops", pops, 2);

        q.push_back(8'h96);
        drive();
        tick();
        for (int t = 0; t <= 6 * BITC + 3; t++) tick();
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("arst_tx_out", Tx_Out, 1);
        chk("arst_busy", Tx_Busy, 0);
        chk("arst_done", Tx_Done, 0);
        repeat (3) tick();
        chk("arst_hold_done", s_done, 0);
        Rst = 1'b0;
        q.push_back(8'h5A);
        drive();
        tick();
        tick();
        chk("arst_restart_bit", s_out, 0);
        chk("arst_restart_busy", s_busy, 1);
        repeat (FRAME + 2) tick();

        for (int i = 0; i < 3000; i++) begin
            tick();
            if (q.size() < 2 && $urandom_range(0, 3) == 0) q.push_back(DB'($urandom));
            CTS = ($urandom_range(0, 4) != 0);
            drive();
        end
        CTS = 1'b1;
        repeat (3 * FRAME + 8) tick();
        chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
